fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the main decoder.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake.
- Captures each returned word in an instruction register and presents it with a valid flag. op/funct feed the decoder; pcplus4 feeds the datapath.
- Supports downstream stall and branch/jump redirect, including squash of an in-flight fetch.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads over a req/ack
// handshake, and presents each returned word to the decoder. Supports
// downstream stall and branch/jump redirect, including squash of a fetch
// that is already in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        instr_accept,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  // StFetch: request at pc outstanding.
  // StHold:  instruction presented, waiting for the consumer.
  // StDrain: redirected while a request was outstanding; wait out its ack
  //          and throw the data away before fetching from the new pc.
  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;
  logic        ack_seen;
  logic        consume;

  assign pc_inc       = pc_q + 32'd4;
  // Low bits are masked rather than sliced so every target bit is used.
  assign redirect_tgt = redirect_pc & ~32'h0000_0003;
  // An ack only counts while a request is actually being driven.
  assign ack_seen     = imem_ack & imem_req;
  assign consume      = instr_accept & ~stall;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (ack_seen) begin
          // A redirect coinciding with the ack squashes the returned word.
          state_d = redirect ? StFetch : StHold;
        end else if (redirect) begin
          state_d = StDrain;
        end
      end
      StHold: begin
        if (redirect || consume) begin
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (ack_seen) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Output decode from state.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      // Gated by reset_n so the request drops the instant reset asserts,
      // even though the state register already sits in StFetch.
      StFetch, StDrain: imem_req = reset_n;
      StHold:           instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  // Next values for pc, instruction register and request address.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          pc_d = redirect_tgt;
        end else if (ack_seen) begin
          instr_d = imem_rdata;
        end
      end
      StHold: begin
        // Redirect wins over both stall and accept.
        if (redirect) begin
          pc_d = redirect_tgt;
        end else if (consume) begin
          pc_d = pc_inc;
        end
      end
      StDrain: begin
        // Last redirect wins; the drained request keeps its old address.
        if (redirect) begin
          pc_d = redirect_tgt;
        end
      end
      default: pc_d = pc_q;
    endcase
    // The request address only moves when a fresh request begins, which keeps
    // imem_addr stable from assertion until the ack.
    req_addr_d = (state_d == StFetch) ? pc_d : req_addr_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= 32'h0000_0000;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
    end
  end

  assign imem_addr = req_addr_q;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign pc        = pc_q;
  assign pcplus4   = pc_inc;

`ifndef SYNTHESIS
  // A waiting request keeps its address until acked.
  addr_stable_a : assert property (@(posedge clk) disable iff (!reset_n)
    (imem_req && !imem_ack) |=> (imem_req && (imem_addr == $past(imem_addr))));

  // Never request while holding a presented instruction.
  hold_no_req_a : assert property (@(posedge clk) disable iff (!reset_n)
    instr_valid |-> !imem_req);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a table of fetch vectors plus hand-written redirect,
// drain, wrap-around and mid-request reset sequences. Expected instructions
// are pushed when the bench's memory acks and popped when instr_valid rises.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        instr_accept;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .instr_accept(instr_accept),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          dly;
    int          stalls;
    logic [31:0] rdata;
    logic [5:0]  op;
    logic [5:0]  funct;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[4];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard and compare against the presented instruction.
  task automatic check_out();
    exp_t        e;
    logic [31:0] p4;
    chk("instr_valid", instr_valid, 32'd1);
    chk("req_low_in_hold", imem_req, 32'd0);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got instr %h, want none", instr);
    end else begin
      e  = exp_q.pop_front();
      p4 = e.pc + 32'd4;
      chk("instr", instr, e.instr);
      chk("pc", pc, e.pc);
      chk("pcplus4", pcplus4, p4);
      chk("op", op, e.op);
      chk("funct", funct, e.funct);
    end
  endtask

  // Serve one request at address a after dly wait cycles, then check delivery.
  task automatic fetch_one(input logic [31:0] a, input int dly, input logic [31:0] rd,
                           input logic [5:0] o, input logic [5:0] f);
    exp_t e;
    for (int k = 0; k < 20 && imem_req !== 1'b1; k++) step();
    chk("req", imem_req, 32'd1);
    chk("addr", imem_addr, a);
    for (int k = 0; k < dly; k++) begin
      imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("wait_valid", instr_valid, 32'd0);
      chk("wait_addr", imem_addr, a);
      chk("wait_req", imem_req, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = rd;
    e = '{rd, a, o, f};
    exp_q.push_back(e);
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check_out();
  endtask

  // Hold under stall for n cycles, then accept and check the next request.
  task automatic hold(input logic [31:0] a, input logic [31:0] rd, input int n);
    logic [31:0] nxt;
    nxt = a + 32'd4;
    for (int s = 0; s < n; s++) begin
      stall        = 1'b1;
      instr_accept = 1'b1;
      step();
      chk("stall_valid", instr_valid, 32'd1);
      chk("stall_pc", pc, a);
      chk("stall_instr", instr, rd);
      chk("stall_req", imem_req, 32'd0);
    end
    stall        = 1'b0;
    instr_accept = 1'b1;
    step();
    instr_accept = 1'b0;
    chk("valid_after_accept", instr_valid, 32'd0);
    chk("next_addr", imem_addr, nxt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h0000_0000, 0, 0, 32'h2008_0005, 6'h08, 6'h05};
    tbl[1] = '{32'h0000_0004, 0, 0, 32'h8C09_0004, 6'h23, 6'h04};
    tbl[2] = '{32'h0000_0008, 3, 0, 32'h0109_5020, 6'h00, 6'h20};
    tbl[3] = '{32'h0000_000C, 0, 5, 32'hAC0A_0008, 6'h2B, 6'h08};

    reset_n      = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = 32'hDEAD_BEEF;
    instr_accept = 1'b0;
    stall        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    #1 reset_n = 1'b0;
    step();
    step();
    chk("rst_req", imem_req, 32'd0);
    chk("rst_valid", instr_valid, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_req", imem_req, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_pc", pc, 32'h0);
    chk("rel_instr", instr, 32'h0);
    chk("rel_valid", instr_valid, 32'd0);

    for (int i = 0; i < 4; i++) begin
      fetch_one(tbl[i].addr, tbl[i].dly, tbl[i].rdata, tbl[i].op, tbl[i].funct);
      hold(tbl[i].addr, tbl[i].rdata, tbl[i].stalls);
    end

    // Redirect while the 0x10 request is still waiting for its ack.
    chk("pre_redir_addr", imem_addr, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    step();
    redirect = 1'b0;
    chk("drain_req", imem_req, 32'd1);
    chk("drain_addr", imem_addr, 32'h10);
    chk("drain_pc", pc, 32'h40);
    chk("drain_valid", instr_valid, 32'd0);
    step();
    chk("drain_addr2", imem_addr, 32'h10);
    chk("drain_valid2", instr_valid, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0010;
    step();
    imem_ack = 1'b0;
    chk("squash_valid", instr_valid, 32'd0);
    chk("post_drain_req", imem_req, 32'd1);
    chk("post_drain_addr", imem_addr, 32'h40);
    fetch_one(32'h40, 0, 32'h0800_0010, 6'h02, 6'h10);
    hold(32'h40, 32'h0800_0010, 0);

    // Redirect coinciding with an ack in FETCH drops the data.
    imem_ack    = 1'b1;
    imem_rdata  = 32'hBAD0_0044;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    imem_ack = 1'b0;
    redirect = 1'b0;
    chk("coinc_valid", instr_valid, 32'd0);
    chk("coinc_addr", imem_addr, 32'h80);
    // Two redirects while draining: the last one wins.
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("dbl_addr", imem_addr, 32'h80);
    chk("dbl_pc", pc, 32'h200);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("dbl_valid", instr_valid, 32'd0);
    chk("dbl_next_addr", imem_addr, 32'h200);
    fetch_one(32'h200, 1, 32'h1000_FFFF, 6'h04, 6'h3F);

    // Redirect in HOLD beats stall and accept.
    stall        = 1'b1;
    instr_accept = 1'b1;
    redirect     = 1'b1;
    redirect_pc  = 32'hFFFF_FFFC;
    step();
    stall        = 1'b0;
    instr_accept = 1'b0;
    redirect     = 1'b0;
    chk("hold_redir_valid", instr_valid, 32'd0);
    chk("hold_redir_addr", imem_addr, 32'hFFFF_FFFC);

    // Wrap-around from the top of the address space.
    fetch_one(32'hFFFF_FFFC, 0, 32'h3C01_1234, 6'h0F, 6'h34);
    hold(32'hFFFF_FFFC, 32'h3C01_1234, 0);
    fetch_one(32'h0, 0, 32'h2008_0005, 6'h08, 6'h05);
    hold(32'h0, 32'h2008_0005, 0);

    // Reset mid-request at 0x4.
    chk("pre_rst_req", imem_req, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", instr_valid, 32'd0);
    chk("mid_rst_instr", instr, 32'h0);
    step();
    reset_n = 1'b1;
    #1;
    chk("rerel_req", imem_req, 32'd1);
    fetch_one(32'h0, 2, 32'h2008_0005, 6'h08, 6'h05);
    hold(32'h0, 32'h2008_0005, 0);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
